imem_arbiter: RTL and testbench

- Shares the single-ported instruction memory between two requesters: CPU fetch (read-only) and the boot/debug loader (read/write).
- Translates byte addresses to word indices and range-checks them.
- Fetch has priority. A starvation counter guarantees loader progress.
- Sits between the fetch stage / loader and the IMEM word array. The memory array has 1-cycle synchronous read.

---
 rtl/imem_arbiter.sv | 147 ++++++++++++++
 tb/tb_imem_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-ported instruction memory between CPU fetch
// (read-only) and the boot/debug loader (read/write). Byte addresses are
// translated to word indices and range-checked. Fetch has priority, and a
// starvation counter lets the loader through after STARVE lost conflicts.
// Optional feature macro: IMARB_WP_EN adds a write-protect input 'wp' that
// turns granted loader writes into error completions without touching memory.
module imem_arbiter #(
   parameter logic [31:0] BASE   = 32'h0000_3000,
   parameter int          DEPTH  = 4096,
   parameter int          AW     = 12,
   parameter int          STARVE = 4
) (
   input  logic          clk,
   input  logic          reset,
`ifdef IMARB_WP_EN
   input  logic          wp,
`endif
   input  logic          f_req,
   input  logic [31:0]   f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [31:0]   f_rdata,
   output logic          f_err,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [31:0]   l_addr,
   input  logic [31:0]   l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [31:0]   l_rdata,
   output logic          l_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   // Who owns the response slot in the cycle after a grant.
   typedef enum logic [1:0] {
      OWN_NONE   = 2'd0,
      OWN_FETCH  = 2'd1,
      OWN_LOADER = 2'd2
   } owner_t;

   localparam logic [3:0]  STARVE_MAX = 4'(STARVE);
   localparam logic [31:0] DEPTH_W    = 32'(DEPTH);

   owner_t     owner, owner_nxt;
   logic       resp_we, resp_we_nxt;
   logic       resp_err, resp_err_nxt;
   logic [3:0] starve_cnt, starve_nxt;

   logic [31:0] f_off, l_off;
   logic        f_bad, l_bad;
   logic        f_win, l_win;
   logic        wr_block;

   // Byte offset from BASE and the bad-address decision for each requester.
   always_comb begin
      f_off = f_addr - BASE;
      l_off = l_addr - BASE;
      f_bad = (f_addr < BASE) || (f_addr[1:0] != 2'b00) || ((f_off >> 2) >= DEPTH_W);
      l_bad = (l_addr < BASE) || (l_addr[1:0] != 2'b00) || ((l_off >> 2) >= DEPTH_W);
   end

   // Arbitration: fetch wins conflicts unless the loader has been starved long enough.
   always_comb begin
      f_win = 1'b0;
      l_win = 1'b0;
      if (reset) begin
         l_win = l_req && (!f_req || (starve_cnt == STARVE_MAX));
         f_win = f_req && !l_win;
      end
   end

`ifdef IMARB_WP_EN
   assign wr_block = l_win && l_we && wp;
`else
   assign wr_block = 1'b0;
`endif

   // Grant-cycle memory strobe, next owner/flags, and starvation counter update.
   always_comb begin
      owner_nxt    = OWN_NONE;
      resp_we_nxt  = 1'b0;
      resp_err_nxt = 1'b0;
      starve_nxt   = starve_cnt;
      f_gnt        = f_win;
      l_gnt        = l_win;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      if (f_win) begin
         owner_nxt    = OWN_FETCH;
         resp_err_nxt = f_bad;
         if (!f_bad) begin
            mem_en   = 1'b1;
            mem_addr = f_off[AW+1:2];
         end
      end else if (l_win) begin
         owner_nxt    = OWN_LOADER;
         resp_we_nxt  = l_we;
         resp_err_nxt = l_bad || wr_block;
         if (!l_bad && !wr_block) begin
            mem_en   = 1'b1;
            mem_we   = l_we;
            mem_addr = l_off[AW+1:2];
            if (l_we) begin
               mem_wdata = l_wdata;
            end
         end
      end
      if (l_win || !l_req) begin
         starve_nxt = 4'd0;
      end else if (f_win && (starve_cnt != STARVE_MAX)) begin
         starve_nxt = starve_cnt + 4'd1;
      end
   end

   // Response-owner register and starvation counter; reset drops any read in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         owner      <= OWN_NONE;
         resp_we    <= 1'b0;
         resp_err   <= 1'b0;
         starve_cnt <= 4'd0;
      end else begin
         owner      <= owner_nxt;
         resp_we    <= resp_we_nxt;
         resp_err   <= resp_err_nxt;
         starve_cnt <= starve_nxt;
      end
   end

   // Response outputs: memory data only for good reads, zero for writes and errors.
   always_comb begin
      f_rvalid = (owner == OWN_FETCH);
      l_rvalid = (owner == OWN_LOADER);
      f_err    = f_rvalid && resp_err;
      l_err    = l_rvalid && resp_err;
      f_rdata  = (f_rvalid && !resp_err) ? mem_rdata : 32'd0;
      l_rdata  = (l_rvalid && !resp_we && !resp_err) ? mem_rdata : 32'd0;
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: scoreboard bench for imem_arbiter. A word-array memory model
// sits behind the DUT; a reference model predicts grants and responses.
// Build with IMARB_WP_EN defined to also exercise write protection.
module tb_imem_arbiter;

   localparam logic [31:0] BASE   = 32'h0000_3000;
   localparam int          DEPTH  = 4096;
   localparam int          AW     = 12;
   localparam int          STARVE = 4;

   logic          clk;
   logic          reset;
   logic          f_req, f_gnt, f_rvalid, f_err;
   logic [31:0]   f_addr, f_rdata;
   logic          l_req, l_we, l_gnt, l_rvalid, l_err;
   logic [31:0]   l_addr, l_wdata, l_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;
`ifdef IMARB_WP_EN
   logic          wp;
`endif

   typedef struct {
      int          cyc;
      logic        err;
      logic [31:0] data;
   } resp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } lreq_t;

   logic [31:0] env_mem [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   resp_t       fexp[$];
   resp_t       lexp[$];
   logic [31:0] fq[$];
   lreq_t       lq[$];
   bit          win_trace[$];
   bit          trace_on = 1'b0;
   bit          f_done = 1'b0;
   bit          l_done = 1'b0;
   int          lost = 0;
   int          cyc = 0;
   int          vectors = 0;
   int          miscompares = 0;

   imem_arbiter #(.BASE(BASE), .DEPTH(DEPTH), .AW(AW), .STARVE(STARVE)) dut (
      .clk(clk),
      .reset(reset),
`ifdef IMARB_WP_EN
      .wp(wp),
`endif
      .f_req(f_req),
      .f_addr(f_addr),
      .f_gnt(f_gnt),
      .f_rvalid(f_rvalid),
      .f_rdata(f_rdata),
      .f_err(f_err),
      .l_req(l_req),
      .l_we(l_we),
      .l_addr(l_addr),
      .l_wdata(l_wdata),
      .l_gnt(l_gnt),
      .l_rvalid(l_rvalid),
      .l_rdata(l_rdata),
      .l_err(l_err),
      .mem_en(mem_en),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory array with one-cycle synchronous read.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) env_mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= env_mem[mem_addr];
      end
   end

   // Cycle number used to time responses against their grants.
   always @(posedge clk) cyc++;

   function automatic bit addr_bad(logic [31:0] a);
      longint x = longint'(a);
      return (x < longint'(BASE)) || ((x % 4) != 0) ||
             (((x - longint'(BASE)) / 4) >= longint'(DEPTH));
   endfunction

   function automatic int word_of(logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 4);
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 19))
         0:       a = BASE - 32'd4;
         1:       a = BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(1, 3));
         2:       a = BASE + 32'(DEPTH * 4);
         3:       a = 32'd0;
         4:       a = BASE + 32'(DEPTH * 4 - 4);
         default: a = BASE + 32'(4 * $urandom_range(0, 31));
      endcase
      return a;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, " f_gnt"},     32'(f_gnt), 32'd0);
      checkOutput({tag, " f_rvalid"},  32'(f_rvalid), 32'd0);
      checkOutput({tag, " f_rdata"},   f_rdata, 32'd0);
      checkOutput({tag, " f_err"},     32'(f_err), 32'd0);
      checkOutput({tag, " l_gnt"},     32'(l_gnt), 32'd0);
      checkOutput({tag, " l_rvalid"},  32'(l_rvalid), 32'd0);
      checkOutput({tag, " l_rdata"},   l_rdata, 32'd0);
      checkOutput({tag, " l_err"},     32'(l_err), 32'd0);
      checkOutput({tag, " mem_en"},    32'(mem_en), 32'd0);
      checkOutput({tag, " mem_we"},    32'(mem_we), 32'd0);
      checkOutput({tag, " mem_addr"},  32'(mem_addr), 32'd0);
      checkOutput({tag, " mem_wdata"}, mem_wdata, 32'd0);
   endtask

   // Reset throws away every outstanding expectation, as the DUT drops in-flight reads.
   always @(negedge reset) begin
      fexp.delete();
      lexp.delete();
      lost   = 0;
      f_done = 1'b0;
      l_done = 1'b0;
   end

   resp_t       ck_r;
   bit          ck_f, ck_l, ck_bad, ck_blk, ck_en, ck_wp;
   // Grant-side checker: predicts the winner and memory strobe, queues the response.
   always @(negedge clk) begin
      if (reset) begin
`ifdef IMARB_WP_EN
         ck_wp = wp;
`else
         ck_wp = 1'b0;
`endif
         ck_l = l_req && (!f_req || (lost == STARVE));
         ck_f = f_req && !ck_l;
         checkOutput("f_gnt", 32'(f_gnt), 32'(ck_f));
         checkOutput("l_gnt", 32'(l_gnt), 32'(ck_l));
         if (ck_f) begin
            ck_bad = addr_bad(f_addr);
            checkOutput("fetch mem_en", 32'(mem_en), 32'(!ck_bad));
            ck_r.cyc  = cyc;
            ck_r.err  = ck_bad;
            ck_r.data = 32'd0;
            if (!ck_bad) begin
               checkOutput("fetch mem_we", 32'(mem_we), 32'd0);
               checkOutput("fetch mem_addr", 32'(mem_addr), 32'(word_of(f_addr)));
               ck_r.data = ref_mem[word_of(f_addr)];
            end
            fexp.push_back(ck_r);
            f_done = 1'b1;
         end else if (ck_l) begin
            ck_bad = addr_bad(l_addr);
            ck_blk = l_we && ck_wp;
            ck_en  = !ck_bad && !ck_blk;
            checkOutput("loader mem_en", 32'(mem_en), 32'(ck_en));
            ck_r.cyc  = cyc;
            ck_r.err  = !ck_en;
            ck_r.data = 32'd0;
            if (ck_en) begin
               checkOutput("loader mem_we", 32'(mem_we), 32'(l_we));
               checkOutput("loader mem_addr", 32'(mem_addr), 32'(word_of(l_addr)));
               if (l_we) begin
                  checkOutput("loader mem_wdata", mem_wdata, l_wdata);
                  ref_mem[word_of(l_addr)] = l_wdata;
               end else begin
                  ck_r.data = ref_mem[word_of(l_addr)];
               end
            end
            lexp.push_back(ck_r);
            l_done = 1'b1;
         end else begin
            checkOutput("idle mem_en", 32'(mem_en), 32'd0);
         end
         if (trace_on && (f_gnt || l_gnt)) win_trace.push_back(l_gnt);
         // Conflicts lost since the loader last got through (or stopped asking).
         if (f_req && l_req && ck_f) lost = (lost < STARVE) ? lost + 1 : lost;
         else                        lost = 0;
      end
   end

   resp_t mon_r;
   // Response monitor: pops the expected response whenever the DUT signals rvalid.
   always @(negedge clk) begin
      if (reset) begin
         if (f_rvalid) begin
            if (fexp.size() == 0) begin
               checkOutput("f_rvalid spurious", 32'd1, 32'd0);
            end else begin
               mon_r = fexp.pop_front();
               checkOutput("f_rvalid latency", 32'(cyc), 32'(mon_r.cyc + 1));
               checkOutput("f_err", 32'(f_err), 32'(mon_r.err));
               checkOutput("f_rdata", f_rdata, mon_r.data);
            end
         end else if (fexp.size() != 0 && fexp[0].cyc < cyc) begin
            checkOutput("f_rvalid missing", 32'd0, 32'd1);
            void'(fexp.pop_front());
         end
         if (l_rvalid) begin
            if (lexp.size() == 0) begin
               checkOutput("l_rvalid spurious", 32'd1, 32'd0);
            end else begin
               mon_r = lexp.pop_front();
               checkOutput("l_rvalid latency", 32'(cyc), 32'(mon_r.cyc + 1));
               checkOutput("l_err", 32'(l_err), 32'(mon_r.err));
               checkOutput("l_rdata", l_rdata, mon_r.data);
            end
         end else if (lexp.size() != 0 && lexp[0].cyc < cyc) begin
            checkOutput("l_rvalid missing", 32'd0, 32'd1);
            void'(lexp.pop_front());
         end
      end
   end

   // Plays out the queued fetch and loader requests, holding each until granted.
   task automatic applyStimulus(input int idle_pct, input int budget);
      int    n = 0;
      lreq_t lr;
      while (1) begin
         @(posedge clk);
         #1;
         if (f_done) begin f_req = 1'b0; f_done = 1'b0; end
         if (l_done) begin l_req = 1'b0; l_done = 1'b0; end
         if (!f_req && fq.size() > 0 && $urandom_range(0, 99) >= idle_pct) begin
            f_req  = 1'b1;
            f_addr = fq.pop_front();
         end
         if (!l_req && lq.size() > 0 && $urandom_range(0, 99) >= idle_pct) begin
            lr      = lq.pop_front();
            l_req   = 1'b1;
            l_we    = lr.we;
            l_addr  = lr.addr;
            l_wdata = lr.data;
         end
         n++;
         if (!f_req && !l_req && fq.size() == 0 && lq.size() == 0 &&
             fexp.size() == 0 && lexp.size() == 0) break;
         if (n > budget) begin
            checkOutput("stream timeout", 32'd0, 32'd1);
            f_req = 1'b0;
            l_req = 1'b0;
            fq.delete();
            lq.delete();
            break;
         end
      end
   endtask

   function automatic lreq_t mk_l(logic we, logic [31:0] a, logic [31:0] d);
      lreq_t r;
      r.we = we; r.addr = a; r.data = d;
      return r;
   endfunction

   logic [31:0] saved;
   initial begin
      reset = 1'b0;
      f_req = 1'b0; f_addr = 32'd0;
      l_req = 1'b0; l_we = 1'b0; l_addr = 32'd0; l_wdata = 32'd0;
`ifdef IMARB_WP_EN
      wp = 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         saved = $urandom;
         env_mem[i] = saved;
         ref_mem[i] = saved;
      end
      env_mem[0] = 32'hA; ref_mem[0] = 32'hA;
      env_mem[1] = 32'hB; ref_mem[1] = 32'hB;
      env_mem[2] = 32'hC; ref_mem[2] = 32'hC;

      #2;
      checkIdleOutputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b1;

      $display("[TB] fetch stream");
      fq.push_back(BASE); fq.push_back(BASE + 32'd4); fq.push_back(BASE + 32'd8);
      applyStimulus(0, 50);

      $display("[TB] loader write then fetch");
      lq.push_back(mk_l(1'b1, BASE + 32'h10, 32'hDEADBEEF));
      applyStimulus(0, 50);
      fq.push_back(BASE + 32'h10);
      applyStimulus(0, 50);
      checkOutput("memory word 4", env_mem[4], 32'hDEADBEEF);

      $display("[TB] conflict starvation");
      win_trace.delete();
      trace_on = 1'b1;
      for (int i = 0; i < 12; i++) fq.push_back(BASE + 32'(4 * i));
      for (int i = 0; i < 3; i++) lq.push_back(mk_l(1'b0, BASE + 32'(4 * (20 + i)), 32'd0));
      applyStimulus(0, 100);
      trace_on = 1'b0;
      checkOutput("conflict grant count", 32'(win_trace.size()), 32'd15);
      for (int i = 0; i < win_trace.size() && i < 15; i++)
         checkOutput($sformatf("conflict grant %0d loader", i), 32'(win_trace[i]),
                     ((i % 5) == 4) ? 32'd1 : 32'd0);

      $display("[TB] bad addresses");
      fq.push_back(32'h2FFC); fq.push_back(32'h3002); fq.push_back(32'h7000);
      lq.push_back(mk_l(1'b0, 32'h2FFC, 32'd0));
      lq.push_back(mk_l(1'b1, 32'h3002, 32'h55AA55AA));
      lq.push_back(mk_l(1'b1, 32'h7000, 32'h12345678));
      applyStimulus(0, 100);

      $display("[TB] reset with read in flight");
      @(posedge clk);
      #1;
      f_req = 1'b1; f_addr = BASE + 32'd8;
      @(negedge clk);
      #1;
      checkOutput("pre-reset f_gnt", 32'(f_gnt), 32'd1);
      reset = 1'b0;
      #1;
      checkIdleOutputs("async reset");
      f_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkOutput("post-reset f_rvalid", 32'(f_rvalid), 32'd0);
      end
      fq.push_back(BASE + 32'd4);
      applyStimulus(0, 50);

`ifdef IMARB_WP_EN
      $display("[TB] write protect");
      saved = env_mem[0];
      wp = 1'b1;
      lq.push_back(mk_l(1'b1, BASE, 32'hCAFEF00D));
      applyStimulus(0, 50);
      wp = 1'b0;
      fq.push_back(BASE);
      applyStimulus(0, 50);
      checkOutput("protected word 0", env_mem[0], saved);
`endif

      $display("[TB] random traffic");
      for (int i = 0; i < 150; i++) fq.push_back(rand_addr());
      for (int i = 0; i < 80; i++) lq.push_back(mk_l(1'($urandom_range(0, 1)), rand_addr(), $urandom));
`ifdef IMARB_WP_EN
      wp = 1'($urandom_range(0, 1));
`endif
      applyStimulus(30, 3000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
